// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader
// Pops bw-bit words from a single-clock FIFO read port and packs `pack`
// consecutive words into one wide beat. The beat is offered downstream on a
// valid/ready handshake. Word 0 (popped first) sits in the least
// significant lane.
//
// Optional feature: define FIFO_PACK_READER_FLUSH_EN to let i_flush emit a
// partially filled group. Without the macro i_flush is ignored and every beat
// carries exactly `pack` words.
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low; clears all state immediately
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO pop request (one word per high cycle)
//   fifo_out    FIFO read data, valid the cycle after fifo_rd
//   i_flush     emit a partial group (only with FIFO_PACK_READER_FLUSH_EN)
//   i_ready     downstream accepts the beat
//   o_valid     packed beat available
//   o_data      packed beat, word k in bits [k*bw +: bw]
//   o_words     number of valid words in o_data
module fifo_pack_reader #(
   parameter int unsigned bw   = 8,
   parameter int unsigned pack = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fifo_empty,
   output logic                        fifo_rd,
   input  logic [bw-1:0]               fifo_out,
   input  logic                        i_flush,
   input  logic                        i_ready,
   output logic                        o_valid,
   output logic [pack*bw-1:0]          o_data,
   output logic [$clog2(pack+1)-1:0]   o_words
);

   localparam int unsigned CW = $clog2(pack + 1);
   localparam logic [CW-1:0] PACK_C = CW'(pack);
   localparam logic [CW-1:0] LAST_C = CW'(pack - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   // Reject configurations outside the supported group size
   if (pack == 0 || pack > 16) begin : g_bad_pack
      $error("fifo_pack_reader: pack must be in 1..16");
   end
   if (bw == 0) begin : g_bad_bw
      $error("fifo_pack_reader: bw must be at least 1");
   end

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t         state_q;
   state_t         state_d;

   logic [CW-1:0]  issue_cnt;
   logic [CW-1:0]  cap_cnt;
   logic           rd_d;

   logic           issue_c;
   logic           capture_c;
   logic           release_c;
   logic           flush_armed_c;
   logic           flush_go_c;
   logic [CW-1:0]  words_d;

`ifndef FIFO_PACK_READER_FLUSH_EN
   logic unused_flush;
   assign unused_flush = i_flush;
`endif

   // Next-state, pop request and beat-size selection
   always_comb begin
      state_d       = state_q;
      issue_c       = 1'b0;
      capture_c     = rd_d;
      release_c     = 1'b0;
      flush_armed_c = 1'b0;
      flush_go_c    = 1'b0;
      words_d       = o_words;

`ifdef FIFO_PACK_READER_FLUSH_EN
      // A pending flush blocks new pops so the group can close once the
      // word already in flight has landed.
      flush_armed_c = i_flush && (cap_cnt != '0);
      flush_go_c    = flush_armed_c && (issue_cnt == cap_cnt);
`endif

      case (state_q)
         FILL: begin
            // reset gating keeps the pop request quiet while reset is held
            issue_c = reset && !fifo_empty && (issue_cnt < PACK_C) && !flush_armed_c;
            if (rd_d && (cap_cnt == LAST_C)) begin
               state_d = HOLD;
               words_d = PACK_C;
            end else if (flush_go_c) begin
               state_d = HOLD;
               words_d = cap_cnt;
            end
         end
         HOLD: begin
            if (i_ready) begin
               state_d   = FILL;
               release_c = 1'b1;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, in-flight flag and lane capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_cnt <= '0;
         cap_cnt   <= '0;
         rd_d      <= 1'b0;
         o_data    <= '0;
         o_words   <= '0;
      end else begin
         rd_d <= issue_c;
         if (release_c) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            o_data    <= '0;
            o_words   <= '0;
         end else begin
            if (issue_c) begin
               issue_cnt <= issue_cnt + ONE_C;
            end
            if (capture_c) begin
               cap_cnt <= cap_cnt + ONE_C;
               for (int unsigned k = 0; k < pack; k++) begin
                  if (cap_cnt == CW'(k)) begin
                     o_data[k*bw +: bw] <= fifo_out;
                  end
               end
            end
            o_words <= words_d;
         end
      end
   end

   assign fifo_rd = issue_c;
   assign o_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Testbench for fifo_pack_reader (bw=8, pack=4). A small FIFO model feeds the
// read port; a word-queue reference model predicts every beat. Covers reset,
// streaming, backpressure, starvation, mid-group reset, random traffic and the
// optional FIFO_PACK_READER_FLUSH_EN partial-group flush.
module tb_fifo_pack_reader;

   localparam int unsigned BW   = 8;
   localparam int unsigned PACK = 4;
   localparam int unsigned WW   = $clog2(PACK + 1);
   localparam int unsigned DW   = PACK * BW;

   logic           clk     = 1'b0;
   logic           reset   = 1'b1;
   logic           i_flush = 1'b0;
   logic           i_ready = 1'b0;
   logic           fifo_empty;
   logic           fifo_rd;
   logic [BW-1:0]  fifo_out;
   logic           o_valid;
   logic [DW-1:0]  o_data;
   logic [WW-1:0]  o_words;

   fifo_pack_reader #(.bw(BW), .pack(PACK)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_out   (fifo_out),
      .i_flush    (i_flush),
      .i_ready    (i_ready),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_words    (o_words)
   );

   always #5 clk = ~clk;

   // FIFO model: registered read data, cleared by the shared reset
   logic [BW-1:0] mem [0:255];
   int unsigned   wr_ptr = 0;
   int unsigned   rd_ptr;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr   <= wr_ptr;
         fifo_out <= '0;
      end else if (fifo_rd && !fifo_empty) begin
         fifo_out <= mem[rd_ptr[7:0]];
         rd_ptr   <= rd_ptr + 1;
      end
   end

   // Reference model and bookkeeping
   logic [BW-1:0] exp_q [$];
   logic [DW-1:0] beat_log [$];
   int            rise_q [$];
   int            n_pass = 0;
   int            n_chk  = 0;
   int            n_fail = 0;
   int            cyc    = 0;
   int            beats  = 0;
   int            rd_cnt = 0;
   int            first_rd = -1;
   bit            allow_partial = 1'b0;
   bit            prev_valid = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [BW-1:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back(w);
   endtask

   function automatic int exp_n();
      if (allow_partial && exp_q.size() < PACK) return exp_q.size();
      return PACK;
   endfunction

   function automatic logic [DW-1:0] model_beat(input int n);
      logic [DW-1:0] b;
      b = '0;
      for (int k = 0; k < n && k < exp_q.size(); k++) b[k*BW +: BW] = exp_q[k];
      return b;
   endfunction

   // One clock: check settled outputs, account for a transfer, advance.
   task automatic cycle();
      int n;
      #1;
      if (fifo_rd) begin
         rd_cnt++;
         if (first_rd < 0) first_rd = cyc;
         check("rd_legal", {62'd0, o_valid, fifo_empty}, 64'd0);
      end
      if (o_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = o_valid;
      if (o_valid) begin
         n = exp_n();
         check("beat_data", o_data, model_beat(n));
         check("beat_words", o_words, n);
         if (i_ready) begin
            beat_log.push_back(o_data);
            for (int k = 0; k < n && exp_q.size() > 0; k++) void'(exp_q.pop_front());
            beats++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_beats(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (beats < target && n < budget) begin
         cycle();
         n++;
      end
      check(tag, beats, target);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed cycle %0d, expected completion before time limit", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int pushed;

      // Reset state
      #2 reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_fifo_rd", fifo_rd, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data",  o_data,  0);
      check("rst_o_words", o_words, 0);
      reset = 1'b1;

      // Stream: two beats from eight preloaded words
      for (int i = 1; i <= 8; i++) push(BW'(i));
      i_ready = 1'b1;
      beats = 0; first_rd = -1; rise_q.delete(); beat_log.delete();
      wait_beats(2, 40, "stream_beats");
      check("stream_beat0", beat_log[0], 32'h04030201);
      check("stream_beat1", beat_log[1], 32'h08070605);
      check("stream_latency", rise_q[0] - first_rd, PACK + 1);
      check("stream_period", rise_q[1] - rise_q[0], PACK + 2);
      check("stream_empty", fifo_empty, 1);
      check("stream_idle", o_valid, 0);

      // Backpressure: beat held for 10 cycles, no pops, one transfer
      i_ready = 1'b0; beats = 0;
      for (int i = 0; i < 8; i++) push(BW'($urandom));
      n = 0;
      while (!o_valid && n < 20) begin cycle(); n++; end
      check("bp_valid", o_valid, 1);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("bp_rd_low", fifo_rd, 0);
         check("bp_valid_hold", o_valid, 1);
      end
      i_ready = 1'b1;
      cycle();
      check("bp_single", beats, 1);
      check("bp_drop", o_valid, 0);
      wait_beats(2, 20, "bp_second");

      // Starvation: two words, then the rest much later
      beats = 0;
      push(8'hA1); push(8'hA2);
      for (int i = 0; i < 20; i++) begin
         cycle();
         check("starve_no_valid", o_valid, 0);
         if (i >= 3) check("starve_rd_low", fifo_rd, 0);
      end
      push(8'hA3); push(8'hA4);
      wait_beats(1, 20, "starve_beat");
      check("starve_order", beat_log[beat_log.size()-1], 32'hA4A3A2A1);

      // Reset after two captures with a third pop in flight
      beats = 0; rd_cnt = 0;
      for (int i = 0; i < 8; i++) push(BW'(8'hB0 + i));
      n = 0;
      while (rd_cnt < 3 && n < 20) begin cycle(); n++; end
      check("rstmid_rd3", rd_cnt, 3);
      check("rstmid_partial", o_data, 32'h0000B1B0);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("rstmid_fifo_rd", fifo_rd, 0);
      check("rstmid_o_valid", o_valid, 0);
      check("rstmid_o_data",  o_data,  0);
      check("rstmid_o_words", o_words, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
      wait_beats(1, 20, "rstmid_beat");
      check("rstmid_clean", beat_log[beat_log.size()-1], 32'hC3C2C1C0);

      // Random arrivals and random backpressure
      beats = 0; pushed = 0; n = 0;
      while (beats < 10 && n < 600) begin
         if (pushed < 40 && $urandom_range(0, 2) != 0) begin
            push(BW'($urandom));
            pushed++;
         end
         i_ready = ($urandom_range(0, 3) != 0);
         cycle();
         n++;
      end
      check("rand_beats", beats, 10);
      check("rand_fifo_empty", fifo_empty, 1);

      // Partial group with flush request
      i_ready = 1'b0; beats = 0;
      push(8'h01); push(8'h02); push(8'h03);
      for (int i = 0; i < 10; i++) cycle();
      check("fl_no_valid", o_valid, 0);
      allow_partial = 1'b1;
      i_flush = 1'b1;
      cycle();
      i_flush = 1'b0;
      cycle();
`ifdef FIFO_PACK_READER_FLUSH_EN
      check("fl_valid", o_valid, 1);
      check("fl_words", o_words, 3);
      check("fl_data",  o_data,  32'h00030201);
      i_ready = 1'b1;
      cycle();
      check("fl_beats", beats, 1);
      check("fl_release", o_valid, 0);
`else
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("nofl_no_valid", o_valid, 0);
      end
      i_ready = 1'b1;
      push(8'h04);
      wait_beats(1, 20, "nofl_beat");
      check("nofl_data", beat_log[beat_log.size()-1], 32'h04030201);
`endif
      allow_partial = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_pack_reader.md
# fifo_pack_reader

Read-side consumer for the single-clock `fifo_top` / `fifo_depth16` buffer. It pops `bw`-bit words from the FIFO read port and packs `pack` consecutive words into one wide word. It presents that word downstream on a valid/ready handshake. It sits between the FIFO and wide-datapath consumers, such as an MAC array input or an SRAM write port.

## Interface
- `bw`, 8, FIFO word width in bits
- `pack`, 4, words per output beat; legal range 1..16
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd`  out  1  FIFO pop request; one word popped per cycle it is high
- `fifo_out`  in  bw  FIFO read data; valid the cycle after `fifo_rd` was high
- `i_flush`  in  1  request to emit a partial group (effective only with the macro)
- `i_ready`  in  1  downstream accepts the beat
- `o_valid`  out  1  packed beat available
- `o_data`  out  pack*bw  packed beat; word k in bits [k*bw +: bw], word 0 popped first
- `o_words`  out  $clog2(pack+1)  number of valid words in `o_data`

## Operation
- States: FILL (issue and capture pops), HOLD (beat presented). Reset state is FILL.
- `issue_cnt` counts pops issued in the current group. `cap_cnt` counts words captured. `rd_d` is `fifo_rd` delayed one cycle.
- `fifo_rd` = (state==FILL) && !`fifo_empty` && (`issue_cnt` < `pack`). It is combinational from registered state and `fifo_empty`.
- When `rd_d` is high, `fifo_out` is written into lane `cap_cnt` and `cap_cnt` increments.
- FILL→HOLD occurs when the capture makes `cap_cnt` equal to `pack`. On that transition, `o_words` is set to `pack`.
- In HOLD, `o_valid`=1. `fifo_rd`=0.
- HOLD→FILL occurs on `o_valid && i_ready`. On that edge, `issue_cnt`, `cap_cnt` and `o_data` are all cleared to 0.
- While `o_valid`=1 and `i_ready`=0, `o_data` and `o_words` hold stable.
- `i_ready` is ignored when `o_valid`=0.
- If `fifo_empty` goes high mid-group, issuing stalls with no timeout. Captures of pops already in flight still complete.
- `pack`=1: each pop becomes one beat.
- Counter width is `$clog2(pack+1)`. Counters never wrap; they are bounded by `pack`.
- Reset mid-group: the partial group and any in-flight word are discarded. Since the FIFO shares the reset, no word is stranded.
- Reset values: `fifo_rd`=0, `o_valid`=0, `o_data`=0, `o_words`=0, state=FILL, all counters 0, `rd_d`=0.

## Timing
- Call the cycle of the first `fifo_rd` of a group cycle 0, with the FIFO never empty and `i_ready`=1.
  - `fifo_rd` is high in cycles 0..pack-1.
  - Captures occur at the ends of cycles 1..pack.
  - `o_valid` is high in cycle pack+1 and the beat transfers at the end of that cycle.
  - `fifo_rd` can reassert in cycle pack+2.
- Sustained throughput is `pack` words per `pack`+2 cycles.
- Latency from the first pop to `o_valid` is `pack`+1 cycles.
- At most one word is in flight. No pop is issued in HOLD, so no capture can overflow.

## Configuration
- `FIFO_PACK_READER_FLUSH_EN` defined:
  - In FILL, `i_flush`=1 with `cap_cnt`≥1 and `issue_cnt`==`cap_cnt` (nothing in flight) forces FILL→HOLD next edge.
  - `o_words`=`cap_cnt`. Unfilled lanes are 0.
  - While `i_flush`=1 and a flush is pending, `fifo_rd` is held low.
  - `i_flush` with `cap_cnt`==0 is ignored.
- Macro undefined: `i_flush` is ignored, flush logic is not compiled in, and `o_words` equals `pack` whenever `o_valid`=1.

## Test plan
- Stream, pack=4, bw=8: preload FIFO with 0x01..0x08, `i_ready`=1 → two beats, `o_data`=0x04030201 then 0x08070605. First `o_valid` is 5 cycles after the first `fifo_rd`. `fifo_empty` is high afterwards.
- Backpressure: hold `i_ready`=0 for 10 cycles after `o_valid` rises → `o_data` stable, `fifo_rd`=0 throughout, single transfer when `i_ready` rises.
- Starvation: FIFO holds 2 words, the rest arrive 20 cycles later → `fifo_rd` low while empty, no `o_valid` until the 4th capture, correct lane order.
- Reset mid-group: assert `reset`=0 after 2 captures → all outputs 0 immediately. After release, the next 4 words form a clean beat.
- Flush (macro defined): 3 words captured, FIFO empty, pulse `i_flush` → `o_valid`=1, `o_words`=3, `o_data`=0x00030201. With the macro undefined, the same stimulus gives no beat.
